pipe_skid_buffer: RTL

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_skid_buffer_pkg.sv | 32 +++
 rtl/pipe_skid_buffer_if.sv | 35 +++
 rtl/pipe_entry_reg.sv | 34 +++
 rtl/pipe_skid_buffer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer_pkg
// Shared pipeline package for all inter-stage buffers (IF/ID, ID/EX, EX/MEM,
// MEM/WB). Holds the default payload/control/statistics widths, the occupancy
// state encoding and a helper that maps a state onto its occupancy count.
// -----------------------------------------------------------------------------
package pipe_skid_buffer_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CTRL_W = 32;
   localparam int DEF_CNT_W  = 16;

   // Occupancy state: the encoding equals the number of held entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   // Occupancy count reported for a given state.
   function automatic logic [1:0] state_count(input buf_state_e s);
      logic [1:0] c;
      case (s)
         ST_EMPTY: c = 2'd0;
         ST_ONE:   c = 2'd1;
         ST_TWO:   c = 2'd2;
         default:  c = 2'd0;
      endcase
      return c;
   endfunction

endpackage : pipe_skid_buffer_pkg

// File: rtl/pipe_skid_buffer_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer_if
// Handshake bundle of one inter-stage buffer: the upstream valid/ready/data/
// ctrl channel, the downstream valid/ready/data/ctrl channel and the flush.
//   slave  : the buffer's view (consumes in_*, flush, out_ready; drives the rest)
//   master : the surrounding pipeline's view (the opposite directions)
// -----------------------------------------------------------------------------
interface pipe_skid_buffer_if
   import pipe_skid_buffer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
)();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              flush;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready, flush,
      output in_ready, out_valid, out_data, out_ctrl
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready, flush,
      input  in_ready, out_valid, out_data, out_ctrl
   );

endinterface : pipe_skid_buffer_if

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One buffer entry ({data, ctrl}) with synchronous clear and load enable.
// Clear has priority over load; otherwise the entry holds.
//   clk  : clock
//   clr  : synchronous clear to all-zero
//   load : capture d
//   d    : next entry value
//   q    : held entry value
// -----------------------------------------------------------------------------
module pipe_entry_reg
   import pipe_skid_buffer_pkg::*;
#(
   parameter int W = DEF_DATA_W + DEF_CTRL_W
)(
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Entry storage: clear, load or hold.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= {W{1'b0}};
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule : pipe_entry_reg

// File: rtl/pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
// Two-entry pipeline skid buffer (head + skid) with flush and a saturating
// stall counter. The head entry drives the outputs directly; the skid entry
// absorbs the one transfer already in flight when downstream stalls, which
// lets in_ready be a register with no path from out_ready/in_valid/flush.
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset, dominates everything
//   bus       : handshake bundle (slave view)
//   count     : occupancy 0..2
//   stall_cnt : cycles with out_valid=1 and out_ready=0, saturating
// Bubbles always carry out_ctrl=0 (NOP); out_data is zeroed on bubbles only
// when ZERO_DATA=1, otherwise it keeps the last head payload.
// -----------------------------------------------------------------------------
module pipe_skid_buffer
   import pipe_skid_buffer_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CTRL_W    = DEF_CTRL_W,
   parameter bit ZERO_DATA = 1'b0,
   parameter int CNT_W     = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             reset,
   pipe_skid_buffer_if.slave bus,
   output logic [1:0]       count,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int               ENT_W     = DATA_W + CTRL_W;
   localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

   buf_state_e       state_r;
   buf_state_e       next_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [1:0]       count_r;
   logic [CNT_W-1:0] stall_cnt_r;

   logic             accept_s;
   logic             pop_s;
   logic             go_empty_s;
   logic             head_load_s;
   logic             head_clr_s;
   logic             skid_load_s;
   logic             skid_clr_s;
   logic [ENT_W-1:0] in_ent_s;
   logic [ENT_W-1:0] head_d_s;
   logic [ENT_W-1:0] head_q_s;
   logic [ENT_W-1:0] skid_q_s;

   assign in_ent_s = {bus.in_data, bus.in_ctrl};
   assign accept_s = bus.in_valid & in_ready_r;
   assign pop_s    = out_valid_r & bus.out_ready;

   // Next state and entry-register controls from the accept/pop/flush events.
   always_comb begin
      next_s      = state_r;
      head_load_s = 1'b0;
      head_d_s    = in_ent_s;
      skid_load_s = 1'b0;
      go_empty_s  = 1'b0;
      if (reset) begin
         next_s = ST_EMPTY;
      end else if (bus.flush) begin
         // Held entries and any same-cycle accept are dropped; a same-cycle
         // pop has already been seen by downstream.
         next_s     = ST_EMPTY;
         go_empty_s = 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  next_s      = ST_ONE;
                  head_load_s = 1'b1;
               end else begin
                  next_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && pop_s) begin
                  next_s      = ST_ONE;
                  head_load_s = 1'b1;
               end else if (accept_s) begin
                  next_s      = ST_TWO;
                  skid_load_s = 1'b1;
               end else if (pop_s) begin
                  next_s     = ST_EMPTY;
                  go_empty_s = 1'b1;
               end else begin
                  next_s = ST_ONE;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop_s) begin
                  next_s      = ST_ONE;
                  head_load_s = 1'b1;
                  head_d_s    = skid_q_s;
               end else begin
                  next_s = ST_TWO;
               end
            end
            default: begin
               next_s     = ST_EMPTY;
               go_empty_s = 1'b1;
            end
         endcase
      end
      // Becoming a bubble: ctrl must read as NOP; payload is kept when
      // ZERO_DATA=0 (the clear below handles ZERO_DATA=1).
      if (go_empty_s && !ZERO_DATA) begin
         head_load_s = 1'b1;
         head_d_s    = {head_q_s[ENT_W-1 -: DATA_W], {CTRL_W{1'b0}}};
      end else begin
         head_load_s = head_load_s;
      end
   end

   assign head_clr_s = reset | (go_empty_s & ZERO_DATA);
   assign skid_clr_s = reset | bus.flush;

   pipe_entry_reg #(.W(ENT_W)) u_head (
      .clk  (clk),
      .clr  (head_clr_s),
      .load (head_load_s),
      .d    (head_d_s),
      .q    (head_q_s)
   );

   pipe_entry_reg #(.W(ENT_W)) u_skid (
      .clk  (clk),
      .clr  (skid_clr_s),
      .load (skid_load_s),
      .d    (in_ent_s),
      .q    (skid_q_s)
   );

   // State, registered handshake/status outputs and the stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         count_r     <= 2'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= next_s;
         count_r     <= state_count(next_s);
         out_valid_r <= (next_s != ST_EMPTY);
         in_ready_r  <= (next_s != ST_TWO);
         if (out_valid_r && !bus.out_ready && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = head_q_s[ENT_W-1 -: DATA_W];
   assign bus.out_ctrl  = head_q_s[CTRL_W-1:0];
   assign count         = count_r;
   assign stall_cnt     = stall_cnt_r;

endmodule : pipe_skid_buffer
